riscv_core_mul_div_ctrl: RTL and testbench
==========================================

# riscv_core_mul_div_ctrl

Execute-stage sequencer for the M-extension, sitting directly upstream of `riscv_core_mul_div`. It accepts decoded MUL/DIV/REM instructions from the issue stage through a valid/ready handshake and registers their operands. It drives the mul/div unit's enable and control, stalls the pipeline for the duration of the operation, and returns one write-back beat per instruction. It resolves RISC-V divide-by-zero and signed-overflow cases itself, without starting the divider, and handles pipeline flush and a divider watchdog.

## Interface
- `XLEN`, 64, datapath width.
- `DIV_TIMEOUT`, 80, maximum number of cycles to wait for divider `done` before aborting.

Ports (name, direction, width, meaning):
- `i_mdctrl_clk` in 1: clock, rising edge.
- `i_mdctrl_rstn` in 1: reset, asynchronous, active-low.
- `i_mdctrl_valid` in 1: issue stage presents an M instruction.
- `o_mdctrl_ready` out 1: controller can accept; 1 only in IDLE.
- `i_mdctrl_funct3` in 3: RISC-V funct3 (000 MUL … 111 REMU).
- `i_mdctrl_isword` in 1: *W variant.
- `i_mdctrl_srcA`, `i_mdctrl_srcB` in XLEN: operands.
- `i_mdctrl_rd` in 5: destination register.
- `i_mdctrl_flush` in 1: kill the in-flight instruction.
- `o_mdctrl_md_srcA`, `o_mdctrl_md_srcB` out XLEN: registered operands to the mul/div unit.
- `o_mdctrl_md_control` out 4: `{1'b0, funct3}`.
- `o_mdctrl_md_isword` out 1: registered isword.
- `o_mdctrl_md_en` out 1: enable to the mul/div unit.
- `i_mdctrl_md_busy`, `i_mdctrl_md_done` in 1: divider status; `done` is a 1-cycle pulse.
- `i_mdctrl_md_result` in XLEN: mul/div unit result.
- `o_mdctrl_stall` out 1: hold upstream pipeline.
- `o_mdctrl_wb_valid` out 1: 1-cycle write-back pulse; no backpressure.
- `o_mdctrl_wb_rd` out 5: destination register for the write-back.
- `o_mdctrl_wb_result` out XLEN: write-back data.
- `o_mdctrl_timeout` out 1: 1-cycle pulse when the watchdog fires.

## Operation
- **States:** IDLE, MUL, SPECIAL, DIV_START, DIV_WAIT, DRAIN, WB.
- **IDLE:**
  - `ready` is 1.
  - On `valid && !flush`, capture operands, funct3, isword and rd.
  - Next state is MUL if funct3[2]=0.
  - Otherwise next state is SPECIAL if the operation is a special case, else DIV_START.
- **Special-case detection** uses `srcB[31:0]`/`srcA[31:0]` when isword, otherwise the full width:
  - Div-by-zero: B==0. DIV/DIVU returns all ones. REM/REMU returns A.
  - Signed overflow (DIV/REM only): A==most-negative and B==−1. DIV returns A. REM returns 0.
  - For isword, the special-case result is the sign-extension of its low 32 bits.
- **MUL:**
  - `md_en`=1 for one cycle.
  - Capture `i_mdctrl_md_result` at the end of the cycle, then go to WB.
- **SPECIAL:** load the computed special-case result, then go to WB.
- **DIV_START:** `md_en`=1 for exactly one cycle, clear the watchdog counter, then go to DIV_WAIT.
- **DIV_WAIT:**
  - `md_en`=0; the counter increments each cycle.
  - On `md_done`, capture the result and go to WB.
  - When the counter reaches DIV_TIMEOUT−1 without `done`, pulse `timeout` and go to IDLE with no write-back.
- **WB:** `wb_valid`=1 with `wb_rd` and `wb_result`, then go to IDLE.
- **Word results:** for isword, `wb_result` = sign-extension of `result[31:0]`, applied to every path.
- **Flush:**
  - In MUL, SPECIAL or WB: the write-back is suppressed and the next state is IDLE.
  - In DIV_START: the `en` pulse is still issued (the divider cannot be aborted), and the next state is DRAIN.
  - In DIV_WAIT: the next state is DRAIN.
  - DRAIN waits for `md_done` or the timeout, discards the result, then returns to IDLE.
  - Flush in IDLE blocks acceptance in that cycle.
- **Stall:** `o_mdctrl_stall` = (state≠IDLE) | (`valid` & state≠IDLE). It is therefore 0 in IDLE.

## Timing
- **Reset values:**
  - state IDLE.
  - `ready` 1.
  - `md_en`, `md_srcA`, `md_srcB`, `md_control`, `md_isword`: 0.
  - `stall`, `wb_valid`, `wb_rd`, `wb_result`, `timeout`: 0.
  - Asserting reset in any state returns to IDLE immediately.
- **Acceptance:** an instruction is accepted in cycle T.
- **MUL latency:** `md_en` in T+1, `wb_valid` in T+2. Back-to-back issue is possible at T+3.
- **Special case:** `wb_valid` in T+2; `md_en` is never asserted.
- **DIV:**
  - `md_en` in T+1 only.
  - When `done` arrives in cycle D ≥ T+2, `wb_valid` is in D+1.
  - A `done` arriving in the same cycle as `flush` in DIV_WAIT is discarded, and the next state is IDLE.
- **Watchdog:** `timeout` is asserted in cycle T+1+DIV_TIMEOUT if no `done` arrives.
- **Registered outputs:** `md_srcA`, `md_srcB`, `md_control` and `md_isword` stay stable from T+1 until the next acceptance.
- **Unused inputs:** `i_mdctrl_md_busy` is used only for assertion checking: it must be 1 in DIV_WAIT.

## Test plan
- MUL, A=7, B=−3, rd=5 → `md_en` at T+1, `md_control`=0000, `wb_valid` at T+2 with rd=5 and result=−21.
- DIVU, A=100, B=7, divider `done` 65 cycles later → single `md_en` pulse with `md_control`=0101, `stall` high throughout, `wb_result`=14 one cycle after `done`.
- DIV, B=0, and REM, A=0x8000000000000000, B=−1 → results 0xFFFF_FFFF_FFFF_FFFF and 0 at T+2; `md_en` never asserted.
- DIVW, A=0x80000000, B=0xFFFFFFFF → `wb_result`=0xFFFFFFFF80000000. REMW, B=0, A=0x1_00000005 → result 5.
- Flush in DIV_WAIT, then `done` 10 cycles later → no `wb_valid`, `ready` returns the cycle after `done`, and the next MUL completes correctly.
- Divider never returns `done` → `timeout` pulse at T+1+80, no write-back, `ready`=1 next cycle. A separate case asserts reset mid-DIV_WAIT → all outputs at their reset values immediately.

Source files
------------

// File: rtl/riscv_core_mul_div_ctrl.sv
// riscv_core_mul_div_ctrl
// Execute-stage sequencer for RISC-V M-extension instructions. Accepts one
// MUL/DIV/REM instruction at a time from issue, registers its operands, drives
// the downstream mul/div unit, stalls the pipeline while busy and produces a
// single write-back beat. Divide-by-zero and signed overflow are answered
// locally without starting the divider. A watchdog aborts a divide whose done
// pulse never arrives; a flush kills the in-flight instruction.
//
// Ports:
//   i_mdctrl_clk / i_mdctrl_rstn       clock (rising edge), async active-low reset
//   i_mdctrl_valid / o_mdctrl_ready    issue handshake (ready only in IDLE)
//   i_mdctrl_funct3/isword/srcA/srcB/rd  decoded instruction fields
//   i_mdctrl_flush                     kill the in-flight instruction
//   o_mdctrl_md_*                      registered operands/control + enable to mul/div
//   i_mdctrl_md_busy/done/result       mul/div unit status and result
//   o_mdctrl_stall                     hold upstream pipeline
//   o_mdctrl_wb_valid/rd/result        one-cycle write-back beat
//   o_mdctrl_timeout                   one-cycle watchdog pulse
module riscv_core_mul_div_ctrl #(
  parameter int XLEN        = 64,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic            i_mdctrl_clk,
  input  logic            i_mdctrl_rstn,
  input  logic            i_mdctrl_valid,
  output logic            o_mdctrl_ready,
  input  logic [2:0]      i_mdctrl_funct3,
  input  logic            i_mdctrl_isword,
  input  logic [XLEN-1:0] i_mdctrl_srcA,
  input  logic [XLEN-1:0] i_mdctrl_srcB,
  input  logic [4:0]      i_mdctrl_rd,
  input  logic            i_mdctrl_flush,
  output logic [XLEN-1:0] o_mdctrl_md_srcA,
  output logic [XLEN-1:0] o_mdctrl_md_srcB,
  output logic [3:0]      o_mdctrl_md_control,
  output logic            o_mdctrl_md_isword,
  output logic            o_mdctrl_md_en,
  input  logic            i_mdctrl_md_busy,
  input  logic            i_mdctrl_md_done,
  input  logic [XLEN-1:0] i_mdctrl_md_result,
  output logic            o_mdctrl_stall,
  output logic            o_mdctrl_wb_valid,
  output logic [4:0]      o_mdctrl_wb_rd,
  output logic [XLEN-1:0] o_mdctrl_wb_result,
  output logic            o_mdctrl_timeout
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, MUL, SPECIAL, DIV_START, DIV_WAIT, DRAIN, WB
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   srca_reg, srcb_reg;
  logic [2:0]        funct3_reg;
  logic              isword_reg;
  logic [4:0]        rd_reg;
  logic [XLEN-1:0]   result_reg, result_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              accept;
  logic              div_expired;

  // Word ops: every result is the sign-extension of its low 32 bits.
  function automatic logic [XLEN-1:0] word_fix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic b_is_zero(input logic w, input logic [XLEN-1:0] b);
    return w ? (b[31:0] == 32'd0) : (b == '0);
  endfunction

  // Most-negative / -1 only overflows for the signed forms (funct3[0]==0).
  function automatic logic signed_ovf(input logic [2:0] f3, input logic w,
                                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (f3[0]) return 1'b0;
    if (w) return (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    return (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  endfunction

  function automatic logic special_hit(input logic [2:0] f3, input logic w,
                                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return f3[2] && (b_is_zero(w, b) || signed_ovf(f3, w, a, b));
  endfunction

  // funct3[1] selects REM; divide-by-zero takes precedence over overflow.
  function automatic logic [XLEN-1:0] special_val(input logic [2:0] f3, input logic w,
                                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] v;
    if (b_is_zero(w, b)) v = f3[1] ? a : '1;
    else                 v = f3[1] ? '0 : a;
    return word_fix(w, v);
  endfunction

  assign div_expired = (cnt_reg == CW'(DIV_TIMEOUT - 1)) && !i_mdctrl_md_done;

  always_comb begin
    state_next        = state_reg;
    result_next       = result_reg;
    cnt_next          = cnt_reg;
    accept            = 1'b0;
    o_mdctrl_md_en    = 1'b0;
    o_mdctrl_wb_valid = 1'b0;
    o_mdctrl_timeout  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_mdctrl_valid && !i_mdctrl_flush) begin
          accept = 1'b1;
          if (!i_mdctrl_funct3[2])
            state_next = MUL;
          else if (special_hit(i_mdctrl_funct3, i_mdctrl_isword, i_mdctrl_srcA, i_mdctrl_srcB))
            state_next = SPECIAL;
          else
            state_next = DIV_START;
        end
      end
      MUL: begin
        o_mdctrl_md_en = 1'b1;
        result_next    = word_fix(isword_reg, i_mdctrl_md_result);
        state_next     = i_mdctrl_flush ? IDLE : WB;
      end
      SPECIAL: begin
        result_next = special_val(funct3_reg, isword_reg, srca_reg, srcb_reg);
        state_next  = i_mdctrl_flush ? IDLE : WB;
      end
      DIV_START: begin
        // The divider cannot be aborted, so the start pulse goes out even under flush.
        o_mdctrl_md_en = 1'b1;
        cnt_next       = '0;
        state_next     = i_mdctrl_flush ? DRAIN : DIV_WAIT;
      end
      DIV_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (div_expired) begin
          o_mdctrl_timeout = 1'b1;
          state_next       = IDLE;
        end else if (i_mdctrl_flush) begin
          state_next = i_mdctrl_md_done ? IDLE : DRAIN;
        end else if (i_mdctrl_md_done) begin
          result_next = word_fix(isword_reg, i_mdctrl_md_result);
          state_next  = WB;
        end
      end
      DRAIN: begin
        // Wait for the killed divide to finish so its done pulse cannot
        // be mistaken for the next instruction's.
        cnt_next = cnt_reg + 1'b1;
        if (i_mdctrl_md_done) begin
          state_next = IDLE;
        end else if (div_expired) begin
          o_mdctrl_timeout = 1'b1;
          state_next       = IDLE;
        end
      end
      WB: begin
        o_mdctrl_wb_valid = !i_mdctrl_flush;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_mdctrl_clk or negedge i_mdctrl_rstn) begin
    if (!i_mdctrl_rstn) begin
      state_reg  <= IDLE;
      srca_reg   <= '0;
      srcb_reg   <= '0;
      funct3_reg <= '0;
      isword_reg <= 1'b0;
      rd_reg     <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      if (accept) begin
        srca_reg   <= i_mdctrl_srcA;
        srcb_reg   <= i_mdctrl_srcB;
        funct3_reg <= i_mdctrl_funct3;
        isword_reg <= i_mdctrl_isword;
        rd_reg     <= i_mdctrl_rd;
      end
    end
  end

  assign o_mdctrl_ready      = (state_reg == IDLE);
  assign o_mdctrl_stall      = (state_reg != IDLE) | (i_mdctrl_valid & (state_reg != IDLE));
  assign o_mdctrl_md_srcA    = srca_reg;
  assign o_mdctrl_md_srcB    = srcb_reg;
  assign o_mdctrl_md_control = {1'b0, funct3_reg};
  assign o_mdctrl_md_isword  = isword_reg;
  assign o_mdctrl_wb_rd      = rd_reg;
  assign o_mdctrl_wb_result  = result_reg;

  // The divider must report busy for as long as we are waiting on it.
  busy_in_wait: assert property (@(posedge i_mdctrl_clk) disable iff (!i_mdctrl_rstn)
                                 (state_reg == DIV_WAIT) |-> i_mdctrl_md_busy);

endmodule

// File: tb/tb_riscv_core_mul_div_ctrl.sv
module tb_riscv_core_mul_div_ctrl;
  localparam int XLEN = 64;
  localparam int TO   = 80;
  localparam int NC   = 2048;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            valid = 1'b0, isword = 1'b0, flush = 1'b0;
  logic            md_busy = 1'b0, md_done = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [4:0]      rd = '0;
  logic [XLEN-1:0] srca = '0, srcb = '0, md_result = '0;
  logic            ready, md_en, md_isword, stall, wb_valid, timeout;
  logic [XLEN-1:0] md_srca, md_srcb, wb_result;
  logic [3:0]      md_control;
  logic [4:0]      wb_rd;

  riscv_core_mul_div_ctrl #(.XLEN(XLEN), .DIV_TIMEOUT(TO)) dut (
    .i_mdctrl_clk(clk), .i_mdctrl_rstn(rstn),
    .i_mdctrl_valid(valid), .o_mdctrl_ready(ready),
    .i_mdctrl_funct3(funct3), .i_mdctrl_isword(isword),
    .i_mdctrl_srcA(srca), .i_mdctrl_srcB(srcb), .i_mdctrl_rd(rd),
    .i_mdctrl_flush(flush),
    .o_mdctrl_md_srcA(md_srca), .o_mdctrl_md_srcB(md_srcb),
    .o_mdctrl_md_control(md_control), .o_mdctrl_md_isword(md_isword),
    .o_mdctrl_md_en(md_en),
    .i_mdctrl_md_busy(md_busy), .i_mdctrl_md_done(md_done),
    .i_mdctrl_md_result(md_result),
    .o_mdctrl_stall(stall),
    .o_mdctrl_wb_valid(wb_valid), .o_mdctrl_wb_rd(wb_rd), .o_mdctrl_wb_result(wb_result),
    .o_mdctrl_timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // Per-cycle expectations, filled from the timing rules when an op is issued.
  bit              e_busy[NC];
  bit              e_en[NC];
  bit              e_wb[NC];
  bit              e_to[NC];
  bit              e_w[NC];
  logic [3:0]      e_ctl[NC];
  logic [4:0]      e_rd[NC];
  logic [XLEN-1:0] e_res[NC], e_a[NC], e_b[NC];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V division semantics, written directly from the ISA rules.
  function automatic logic [31:0] div32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
    if (f3[0]) return f3[1] ? a % b : a / b;
    sa = a; sb = b;
    return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [63:0] div64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    if (b == 64'd0) return f3[1] ? a : '1;
    if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) return f3[1] ? 64'd0 : a;
    if (f3[0]) return f3[1] ? a % b : a / b;
    sa = a; sb = b;
    return f3[1] ? 64'(sa % sb) : 64'(sa / sb);
  endfunction

  function automatic logic [63:0] ref_md(input logic [2:0] f3, input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    if (!f3[2]) r = a * b;
    else if (w) r = {32'd0, div32(f3, a[31:0], b[31:0])};
    else        r = div64(f3, a, b);
    return w ? sx32(r[31:0]) : r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input bit w, input logic [63:0] a, input logic [63:0] b);
    bit bz, ov;
    bz = w ? (b[31:0] == 0) : (b == 0);
    ov = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == '1));
    return f3[2] && (bz || ov);
  endfunction

  // Compare process: every cycle, the DUT against the model expectations.
  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      chk("ready",    {63'd0, ready},    {63'd0, !e_busy[cyc]});
      chk("stall",    {63'd0, stall},    {63'd0, e_busy[cyc]});
      chk("md_en",    {63'd0, md_en},    {63'd0, e_en[cyc]});
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, e_wb[cyc]});
      chk("timeout",  {63'd0, timeout},  {63'd0, e_to[cyc]});
      if (e_en[cyc]) begin
        chk("md_control", {60'd0, md_control}, {60'd0, e_ctl[cyc]});
        chk("md_srcA",    md_srca, e_a[cyc]);
        chk("md_srcB",    md_srcb, e_b[cyc]);
        chk("md_isword",  {63'd0, md_isword}, {63'd0, e_w[cyc]});
      end
      if (e_wb[cyc]) begin
        chk("wb_rd",     {59'd0, wb_rd}, {59'd0, e_rd[cyc]});
        chk("wb_result", wb_result, e_res[cyc]);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"},      {63'd0, ready},      64'd1);
    chk({tag, "_md_en"},      {63'd0, md_en},      64'd0);
    chk({tag, "_md_srcA"},    md_srca,             64'd0);
    chk({tag, "_md_srcB"},    md_srcb,             64'd0);
    chk({tag, "_md_control"}, {60'd0, md_control}, 64'd0);
    chk({tag, "_md_isword"},  {63'd0, md_isword},  64'd0);
    chk({tag, "_stall"},      {63'd0, stall},      64'd0);
    chk({tag, "_wb_valid"},   {63'd0, wb_valid},   64'd0);
    chk({tag, "_wb_rd"},      {59'd0, wb_rd},      64'd0);
    chk({tag, "_wb_result"},  wb_result,           64'd0);
    chk({tag, "_timeout"},    {63'd0, timeout},    64'd0);
  endtask

  // Issue one op in the current cycle T and play the mul/div unit.
  // dly: divider done arrives dly cycles after the md_en cycle (-1 = never).
  // fl:  flush asserted in cycle T+fl (-1 = none; 1 = MUL state, >=2 = DIV_WAIT).
  task automatic run_op(input logic [2:0] f3, input bit w, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] r, input int dly, input int fl,
                        input logic [63:0] lit, input bit use_lit, input string tag);
    int t, last, d, wbc, toc;
    bit sp;
    logic [63:0] exp_r, div_raw;
    t = cyc;
    exp_r = ref_md(f3, w, a, b);
    sp = is_special(f3, w, a, b);
    d = -1; wbc = -1; toc = -1;
    if (!f3[2]) begin
      last = (fl == 1) ? t + 1 : t + 2;
      if (fl != 1) wbc = t + 2;
    end else if (sp) begin
      last = t + 2; wbc = t + 2;
    end else begin
      if (dly >= 0) d = t + 1 + dly;
      if (fl >= 2)        last = d;
      else if (dly >= 0) begin last = d + 1; wbc = d + 1; end
      else begin last = t + 1 + TO; toc = last; end
    end
    if (!sp) begin
      e_en[t+1] = 1'b1; e_ctl[t+1] = {1'b0, f3};
      e_a[t+1] = a; e_b[t+1] = b; e_w[t+1] = w;
    end
    for (int c = t + 1; c <= last; c++) e_busy[c] = 1'b1;
    if (wbc >= 0) begin e_wb[wbc] = 1'b1; e_res[wbc] = exp_r; e_rd[wbc] = r; end
    if (toc >= 0) e_to[toc] = 1'b1;
    // Word results come back with junk in the upper half to exercise sign-extension.
    div_raw = w ? {32'hDEAD_BEEF, exp_r[31:0]} : exp_r;

    valid = 1'b1; funct3 = f3; isword = w; srca = a; srcb = b; rd = r;
    for (int c = t + 1; c <= last + 1; c++) begin
      step();
      valid = 1'b0;
      srca = {$urandom, $urandom};
      srcb = {$urandom, $urandom};
      rd = 5'($urandom);
      flush = (fl > 0) && (c == t + fl);
      md_done = (d >= 0) && (c == d);
      md_busy = f3[2] && !sp && (c >= t + 2) && ((d >= 0) ? (c <= d) : (c <= t + 1 + TO));
      if (!f3[2] && c == t + 1) md_result = a * b;
      else if (c == d)          md_result = div_raw;
      else                      md_result = 64'h5A5A_5A5A_A5A5_A5A5;
      if (use_lit && c == wbc) begin
        @(negedge clk);
        chk(tag, wb_result, lit);
      end
      if (c == toc) begin
        @(negedge clk);
        chk(tag, {63'd0, timeout}, 64'd1);
      end
    end
  endtask

  initial begin
    int t;
    @(negedge clk);
    chk_reset("reset_init");
    step(); step();
    rstn = 1'b1;
    chk_on = 1'b1;
    step();

    run_op(3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, -1, -1, 64'hFFFF_FFFF_FFFF_FFEB, 1, "mul_7_x_m3");
    run_op(3'b101, 0, 64'd100, 64'd7, 5'd9, 65, -1, 64'd14, 1, "divu_100_7");
    run_op(3'b100, 0, 64'd123, 64'd0, 5'd1, -1, -1, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by_zero");
    run_op(3'b110, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, -1, -1, 64'd0, 1, "rem_ovf");
    run_op(3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd3, -1, -1, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    run_op(3'b110, 1, 64'h0000_0001_0000_0005, 64'd0, 5'd6, -1, -1, 64'd5, 1, "remw_by_zero");
    run_op(3'b000, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd8, -1, -1, 64'hFFFF_FFFF_FFFF_FFFE, 1, "mulw_wrap");
    run_op(3'b110, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 2, -1, 64'hFFFF_FFFF_FFFF_FFFF, 1, "rem_m7_2");
    run_op(3'b100, 1, 64'hFFFF_FFFF_FFFF_FFF6, 64'd3, 5'd11, 4, -1, 64'hFFFF_FFFF_FFFF_FFFD, 1, "divw_m10_3");
    run_op(3'b100, 0, 64'd50, 64'd5, 5'd12, 14, 5, 64'd0, 0, "div_flush_wait");
    run_op(3'b000, 0, 64'h1234, 64'h10, 5'd13, -1, -1, 64'h12340, 1, "mul_after_flush");
    run_op(3'b000, 0, 64'd3, 64'd4, 5'd14, -1, 1, 64'd0, 0, "mul_flush");
    run_op(3'b101, 0, 64'd10, 64'd3, 5'd15, -1, -1, 64'd0, 0, "div_timeout");

    // Reset while waiting on the divider.
    t = cyc;
    e_en[t+1] = 1'b1; e_ctl[t+1] = 4'b0100; e_a[t+1] = 64'd9; e_b[t+1] = 64'd3; e_w[t+1] = 1'b0;
    for (int c = t + 1; c <= t + 4; c++) e_busy[c] = 1'b1;
    valid = 1'b1; funct3 = 3'b100; isword = 1'b0; srca = 64'd9; srcb = 64'd3; rd = 5'd4;
    for (int c = t + 1; c <= t + 4; c++) begin
      step();
      valid = 1'b0;
      md_busy = (c >= t + 2);
    end
    #2;
    chk_on = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset("reset_mid_div");
    step();
    md_busy = 1'b0;
    rstn = 1'b1;
    chk_on = 1'b1;

    run_op(3'b000, 0, 64'd6, 64'd7, 5'd16, -1, -1, 64'd42, 1, "mul_after_reset");
    step();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
